// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types for the bit-serial subtractor: FSM states, encodings, minterm decoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package serial_sub_ctrl_pkg;

    // 2-bit state encodings, kept as named constants so that other blocks can
    // decode the controller state without depending on the enum type.
    localparam logic [1:0] ENC_IDLE = 2'b00;
    localparam logic [1:0] ENC_RUN  = 2'b01;
    localparam logic [1:0] ENC_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } state_t;

    // One-hot 3:8 decode; bit k is set when sel == k.
    function automatic logic [7:0] dec3to8(input logic [2:0] sel);
        dec3to8 = 8'b0000_0001 << sel;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// 1-bit full subtractor a - b - c_in built as a 3:8 decoder feeding minterm ORs.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module fs_cell
    import serial_sub_ctrl_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic d,
    output logic borrow
);

    logic [7:0] m;

    // Minterm index is {a, b, c_in}; difference is odd parity, borrow is set
    // whenever b + c_in exceeds a.
    always_comb begin
        m      = dec3to8({a, b, c_in});
        d      = m[1] | m[2] | m[4] | m[7];
        borrow = m[1] | m[2] | m[3] | m[7];
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor A - B - bin, one bit per clock, LSB first.
// Latency: done high the cycle after the WIDTH-th edge following the accepting edge; WIDTH+1 cycles/result back-to-back.
// Backpressure: start is ignored while busy; operands are only sampled on the accepting edge.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_nxt;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;

    logic             load;
    logic             step;
    logic             last;

    logic             cell_d;
    logic             cell_borrow;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    // The single subtractor cell always works on the current LSBs and the carried borrow.
    fs_cell u_fs_cell (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .c_in   (brw_q),
        .d      (cell_d),
        .borrow (cell_borrow)
    );

    // Difference bits enter at the MSB and walk down, so after WIDTH steps bit 0 is the first result bit.
    assign diff_nxt = {cell_d, diff_sh[WIDTH-1:1]};

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; DONE may reload directly for back-to-back operation.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shifters, running borrow and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            diff_sh <= '0;
            brw_q   <= bin;
            cnt_q   <= '0;
        end else if (step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= diff_nxt;
            brw_q   <= cell_borrow;
            // Hold at the last index rather than wrapping; the count reloads on the next start.
            cnt_q   <= last ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Result registers only change on the final bit, so diff/bout stay stable through RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (last) begin
            diff_q <= diff_nxt;
            bout_q <= cell_borrow;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule
